// File: rtl/aes_inv_key_sched.sv
// Reverse AES-128 key schedule: walks from the round-10 key back to round 0,
// one round key per valid/ready handshake.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  assign y = SBOX[a];
endmodule

module aes_inv_key_sched (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [127:0] i_key_last,
  input  logic         i_ready,
  output logic [127:0] o_rkey,
  output logic [3:0]   o_round,
  output logic         o_valid,
  output logic         o_busy,
  output logic         o_done
);
  localparam int NUM_LANES = 4;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t         state_q, state_d;
  logic [127:0]   key_q, key_d;
  logic [3:0]     round_q, round_d;
  logic           done_q, done_d;

  logic [31:0]    w4, w5, w6, w7, w0, w1, w2, w3;
  logic [7:0]     rcon;
  logic [NUM_LANES-1:0][7:0] rot_b, sub_b;
  logic [127:0]   key_prev;
  logic           hs;

  assign {w4, w5, w6, w7} = key_q;
  assign w3 = w7 ^ w6;
  assign w2 = w6 ^ w5;
  assign w1 = w5 ^ w4;
  assign rot_b = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_sub
    aes_sbox u_sbox (.a(rot_b[g]), .y(sub_b[g]));
  end

  always_comb begin
    rcon = 8'h00;
    case (round_q)
      4'd1:  rcon = 8'h01;
      4'd2:  rcon = 8'h02;
      4'd3:  rcon = 8'h04;
      4'd4:  rcon = 8'h08;
      4'd5:  rcon = 8'h10;
      4'd6:  rcon = 8'h20;
      4'd7:  rcon = 8'h40;
      4'd8:  rcon = 8'h80;
      4'd9:  rcon = 8'h1b;
      4'd10: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign w0       = w4 ^ sub_b ^ {rcon, 24'h0};
  assign key_prev = {w0, w1, w2, w3};
  assign hs       = (state_q == EMIT) & i_ready;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (i_start) begin
        state_d = EMIT;
        key_d   = i_key_last;
        round_d = 4'd10;
      end
      EMIT: if (hs) begin
        if (round_q == 4'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          key_d   = key_prev;
          round_d = round_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  assign o_rkey  = key_q;
  assign o_round = round_q;
  assign o_valid = (state_q == EMIT);
  assign o_busy  = (state_q == EMIT);
  assign o_done  = done_q;
endmodule

// File: doc/aes_inv_key_sched.md
# aes_inv_key_sched

Reverse AES-128 key-schedule engine for the decryption datapath. It takes the final (round-10) round key and walks the key expansion backwards. It emits round keys 10, 9, …, 0 in the order the inverse cipher consumes them, using a descending round-constant sequence (0x36, 0x1b, 0x80 … 0x01). It sits between the key-load register and the inverse round datapath, and hands off keys through a valid/ready handshake.

## Interface
Parameters:
- none; the block is fixed to AES-128 (10 rounds, 4 words per key).

Ports:
- `i_clk` input 1: single clock, rising edge.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_start` input 1: one-cycle request to begin a schedule; sampled only in IDLE.
- `i_key_last` input 128: round-10 key, sampled on the accepted `i_start`. Word 0 is [127:96]; byte 0 is [127:120].
- `i_ready` input 1: consumer accepts `o_rkey` this cycle.
- `o_rkey` output 128: current round key.
- `o_round` output 4: round index of `o_rkey` (10 down to 0).
- `o_valid` output 1: `o_rkey`/`o_round` are valid.
- `o_busy` output 1: high from the accepted start until the cycle `o_done` is asserted.
- `o_done` output 1: one-cycle pulse after round 0 is accepted.

## Operation
- FSM states: IDLE and EMIT.
- **IDLE**:
  - Outputs `o_valid=0`, `o_busy=0`.
  - On `i_start=1`: register `i_key_last` into the key register, set round=10, go to EMIT.
- **EMIT**:
  - `o_valid=1`, `o_busy=1`.
  - Handshake = `o_valid & i_ready`.
  - Handshake with round>0: key register ← previous key, round ← round−1, stay in EMIT.
  - Handshake with round=0: go to IDLE, pulse `o_done` for one cycle, deassert `o_busy`.
  - No handshake: key and round hold stable.
- Previous-key computation (combinational from the current key `w4..w7` with round r; produces `w0..w3`):
  - `w3 = w7^w6`
  - `w2 = w6^w5`
  - `w1 = w5^w4`
  - `w0 = w4 ^ SubWord(RotWord(w3)) ^ {rcon(r),24'h0}`
  - RotWord is a left rotate by one byte. SubWord applies the forward AES S-box per byte, as an internal combinational 256-entry table (4 instances).
  - `rcon(r)`, r=1..10: 01,02,04,08,10,20,40,80,1b,36. r=0 never drives computation.
- All XOR and byte lanes are 8/32/128-bit exact; there are no carries.
- `i_start` in EMIT is ignored. `i_key_last` changes after start have no effect.
- The consumer may hold `i_ready` low indefinitely; `o_rkey` must not change while `o_valid & !i_ready`.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, `o_rkey=0`, `o_round=0`, `o_valid=0`, `o_busy=0`, `o_done=0`.
- Reset asserted mid-schedule aborts immediately to the reset values. No `o_done` is pulsed.
- `i_start` accepted at edge N gives `o_valid=1`, `o_round=10` from after edge N, i.e. visible in cycle N+1.
- With `i_ready` held high, one key is produced per cycle: 11 beats (rounds 10..0) over cycles N+1..N+11. `o_done=1` in cycle N+12, together with `o_valid=0` and `o_busy=0`.
- A new `i_start` is accepted in the same cycle `o_done` is high (the FSM is in IDLE).
- The combinational path per cycle is one S-box plus XOR depth. Registered outputs only; nothing is combinational from inputs to outputs.

## Test plan
- **FIPS-197 key with `i_ready`=1.** Start with `i_key_last=d014f9a8c9ee2589e13f0cc8b6630ca6`. Required response:
  - beat 1: round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - beat 2: round 9 = ac7766f319fadc2128d12941575c006e
  - beat 10: round 1 = a0fafe1788542cb123a339392a6c7605
  - beat 11: round 0 = 2b7e151628aed2a6abf7158809cf4f3c
  - then `o_done` pulses exactly once, in cycle N+12.
- **Backpressure.** Same vector with `i_ready` random (~50%). Keys and round order must be identical, `o_rkey` must be stable whenever `i_ready=0`, and `o_done` comes one cycle after the round-0 handshake.
- **Start while busy.** Pulse `i_start` with a different key at round 5. The sequence continues unaffected, `o_busy` stays 1, and no restart occurs.
- **Reset mid-operation.** Assert `i_rst_n=0` at round 4. All outputs go to 0 immediately with no `o_done`. After release, a fresh start yields the correct round-10 key one cycle later.
- **Back-to-back.** Assert `i_start` in the `o_done` cycle with the all-zero round-10 key. Round 9 must equal the reverse-expansion model output, and the golden model is checked for all 11 beats.
- **Random keys.** 1000 random round-10 keys checked against a forward-expansion reference model: expand the model's recovered round-0 key and compare all 11 keys.
